// File: rtl/operacional_param.sv
// Electronic door-lock controller: keypad PIN entry, slot/master matching,
// escalating lockout after failures, auto-relock and door-ajar alarm.
module operacional_param #(
    parameter int N_PINS   = 4,
    parameter int N_DIGITS = 4,
    parameter int TICK_HZ  = 1000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    input  logic                             sensor_de_contato,
    input  logic                             botao_interno,
    input  logic [N_PINS*(1+4*N_DIGITS)-1:0] pin_table,
    input  logic [4*N_DIGITS-1:0]            master_pin,
    input  logic [15:0]                      tranca_aut_time,
    input  logic [15:0]                      bip_time,
    input  logic                             bip_status,
    input  logic                             setup_end,
    output logic                             tranca,
    output logic                             bip,
    output logic                             setup_on,
    output logic                             lockout,
    output logic [2:0]                       tentativas,
    output logic [3:0]                       match_idx
);

    localparam int SW = 1 + 4*N_DIGITS;
    localparam int BW = 4*N_DIGITS;
    localparam int PW = $clog2(TICK_HZ);
    localparam int CW = $clog2(N_DIGITS + 1);

    typedef enum logic [2:0] {
        MONTAR_PIN,
        VERIFICAR,
        ESPERA,
        SETUP,
        DESTRAVADA,
        ABERTA
    } state_t;

    state_t          r_state, w_next;
    logic            r_kv_d;
    logic [BW-1:0]   r_buf;
    logic [CW-1:0]   r_nd;
    logic [PW-1:0]   r_pre;
    logic [15:0]     r_cnt;

    logic            w_press, w_digit, w_clear, w_enter;
    logic            w_tick, w_inc;
    logic [15:0]     w_cnt_next, w_cnt_eff, w_wait;
    logic            w_full, w_is_master, w_slot_hit;
    logic [3:0]      w_slot;

    always_comb begin
        w_press    = key_valid & ~r_kv_d;
        w_digit    = w_press && (key_code <= 4'd9);
        w_clear    = w_press && (key_code == 4'hE);
        w_enter    = w_press && (key_code == 4'hF);
        w_tick     = (r_pre == PW'(TICK_HZ - 1));
        w_inc      = w_tick && (r_cnt != '1);
        w_cnt_next = r_cnt + {15'd0, w_inc};
    end

    // Lowest enabled slot wins; an incomplete buffer never matches anything.
    always_comb begin
        w_full      = (r_nd == CW'(N_DIGITS));
        w_is_master = w_full && (r_buf == master_pin);
        w_slot_hit  = 1'b0;
        w_slot      = '0;
        for (int unsigned i = 0; i < N_PINS; i++) begin
            if (!w_slot_hit && w_full && pin_table[i*SW + SW - 1]
                && (pin_table[i*SW +: BW] == r_buf)) begin
                w_slot_hit = 1'b1;
                w_slot     = 4'(i);
            end
        end
    end

    always_comb begin
        case (tentativas)
            3'd3:    w_wait = 16'd10;
            3'd4:    w_wait = 16'd20;
            3'd5:    w_wait = 16'd30;
            default: w_wait = 16'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= MONTAR_PIN;
        else     r_state <= w_next;
    end

    // Timed exits compare against the count as it will be after this edge,
    // so the visible dwell is exactly the programmed number of seconds.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MONTAR_PIN: begin
                if (botao_interno)  w_next = DESTRAVADA;
                else if (w_enter)   w_next = VERIFICAR;
            end
            VERIFICAR: begin
                if (w_is_master)     w_next = SETUP;
                else if (w_slot_hit) w_next = DESTRAVADA;
                else                 w_next = ESPERA;
            end
            ESPERA: begin
                if (w_cnt_next >= w_wait) w_next = MONTAR_PIN;
            end
            SETUP: begin
                if (setup_end) w_next = MONTAR_PIN;
            end
            DESTRAVADA: begin
                if (!sensor_de_contato) w_next = ABERTA;
                else if (botao_interno || (w_cnt_next >= tranca_aut_time))
                    w_next = MONTAR_PIN;
            end
            ABERTA: begin
                if (sensor_de_contato) w_next = DESTRAVADA;
            end
            default: w_next = MONTAR_PIN;
        endcase
        w_cnt_eff = (w_next != r_state) ? 16'd0 : w_cnt_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kv_d     <= 1'b0;
            r_buf      <= '0;
            r_nd       <= '0;
            r_pre      <= '0;
            r_cnt      <= '0;
            tentativas <= '0;
            match_idx  <= 4'hF;
            tranca     <= 1'b1;
            bip        <= 1'b0;
            setup_on   <= 1'b0;
            lockout    <= 1'b0;
        end else begin
            r_kv_d <= key_valid;

            if (w_next != r_state) begin
                r_pre <= '0;
                r_cnt <= '0;
            end else begin
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
                r_cnt <= w_cnt_next;
            end

            if (r_state == VERIFICAR || (r_state != ESPERA && w_clear)) begin
                r_buf <= '0;
                r_nd  <= '0;
            end else if (r_state != ESPERA && w_digit) begin
                r_buf <= {r_buf[BW-5:0], key_code};
                if (r_nd != CW'(N_DIGITS)) r_nd <= r_nd + CW'(1);
            end

            if (r_state == VERIFICAR) begin
                if (w_is_master) begin
                    tentativas <= '0;
                    match_idx  <= 4'h8;
                end else if (w_slot_hit) begin
                    tentativas <= '0;
                    match_idx  <= w_slot;
                end else begin
                    tentativas <= (tentativas == 3'd5) ? 3'd5 : tentativas + 3'd1;
                    match_idx  <= 4'hF;
                end
            end

            tranca   <= !(w_next == DESTRAVADA || w_next == ABERTA);
            setup_on <= (w_next == SETUP);
            lockout  <= (w_next == ESPERA);
            bip      <= (w_next == ABERTA) && bip_status && (w_cnt_eff >= bip_time);
        end
    end

endmodule

// File: tb/tb_operacional_param.sv
// Self-checking bench for operacional_param: PIN vector table, timed corner
// sequences and randomized entries against a queue-based outcome model.
module tb_operacional_param;

    localparam int NP = 4;
    localparam int ND = 4;
    localparam int HZ = 10;

    logic              clk = 1'b0;
    logic              rst, key_valid, sensor, botao, bip_status, setup_end;
    logic [3:0]        key_code;
    logic [NP*17-1:0]  pin_table;
    logic [15:0]       master_pin, aut, bip_time;
    logic              tranca, bip, setup_on, lockout;
    logic [2:0]        tentativas;
    logic [3:0]        match_idx;

    int checks = 0;
    int failures = 0;

    operacional_param #(.N_PINS(NP), .N_DIGITS(ND), .TICK_HZ(HZ)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .sensor_de_contato(sensor), .botao_interno(botao),
        .pin_table(pin_table), .master_pin(master_pin),
        .tranca_aut_time(aut), .bip_time(bip_time), .bip_status(bip_status),
        .setup_end(setup_end), .tranca(tranca), .bip(bip), .setup_on(setup_on),
        .lockout(lockout), .tentativas(tentativas), .match_idx(match_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] keys;
        int          n;
        logic        e_tranca;
        logic        e_setup;
        logic        e_lock;
        logic [2:0]  e_tent;
        logic [3:0]  e_idx;
    } vec_t;

    vec_t vt[10];
    logic [3:0] kq[$];
    logic [3:0] mb[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_tranca"}, {31'd0, tranca}, 32'd1);
        chk({nm, "_bip"}, {31'd0, bip}, 32'd0);
        chk({nm, "_setup"}, {31'd0, setup_on}, 32'd0);
        chk({nm, "_lock"}, {31'd0, lockout}, 32'd0);
        chk({nm, "_tent"}, {29'd0, tentativas}, 32'd0);
        chk({nm, "_idx"}, {28'd0, match_idx}, 32'hF);
    endtask

    task automatic send_code(input logic [15:0] c);
        for (int d = 3; d >= 0; d--) press(c[d*4 +: 4]);
        press(4'hF);
    endtask

    task automatic measure_lock(output int n);
        n = 0;
        while (lockout === 1'b1 && n < 1000) begin
            n++;
            step();
        end
    endtask

    task automatic count_until_tranca(input int limit, output int n);
        n = 0;
        while (tranca !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    function automatic int lock_secs(input int t);
        if (t <= 2) return 1;
        if (t == 3) return 10;
        if (t == 4) return 20;
        return 30;
    endfunction

    function automatic logic [15:0] rand_code();
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[11:0], 4'($urandom_range(0, 9))};
        return r;
    endfunction

    task automatic set_slot(input int s, input logic st, input logic [15:0] dg);
        pin_table[s*17 +: 17] = {st, dg};
    endtask

    initial begin
        int n;
        int tent_m;
        int exp_durs[6];
        logic [2:0] exp_tents[6];
        logic [15:0] m_master;
        logic [15:0] sd[4];
        logic st[4];

        rst = 1'b1; key_valid = 1'b0; key_code = '0; sensor = 1'b1; botao = 1'b0;
        bip_status = 1'b0; setup_end = 1'b0; aut = 16'd1000; bip_time = 16'd1000;
        master_pin = 16'h1234;
        pin_table = '0;
        set_slot(0, 1'b1, 16'h0000);
        set_slot(1, 1'b1, 16'h5678);
        set_slot(2, 1'b0, 16'h4321);
        set_slot(3, 1'b1, 16'h0000);
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        vt[0] = '{32'h0000,    4, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0};
        vt[1] = '{32'h1234,    4, 1'b1, 1'b1, 1'b0, 3'd0, 4'h8};
        vt[2] = '{32'h5678,    4, 1'b0, 1'b0, 1'b0, 3'd0, 4'h1};
        vt[3] = '{32'h4321,    4, 1'b1, 1'b0, 1'b1, 3'd1, 4'hF};
        vt[4] = '{32'h12E0000, 7, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0};
        vt[5] = '{32'h000,     3, 1'b1, 1'b0, 1'b1, 3'd1, 4'hF};
        vt[6] = '{32'h91234,   5, 1'b1, 1'b1, 1'b0, 3'd0, 4'h8};
        vt[7] = '{32'h9999,    4, 1'b1, 1'b0, 1'b1, 3'd1, 4'hF};
        vt[8] = '{32'hE5678,   5, 1'b0, 1'b0, 1'b0, 3'd0, 4'h1};
        vt[9] = '{32'h56789,   5, 1'b1, 1'b0, 1'b1, 3'd1, 4'hF};

        for (int v = 0; v < 10; v++) begin
            do_reset();
            for (int i = vt[v].n - 1; i >= 0; i--) press(vt[v].keys[i*4 +: 4]);
            press(4'hF);
            chk($sformatf("vec%0d_tranca", v), {31'd0, tranca}, {31'd0, vt[v].e_tranca});
            chk($sformatf("vec%0d_setup", v), {31'd0, setup_on}, {31'd0, vt[v].e_setup});
            chk($sformatf("vec%0d_lock", v), {31'd0, lockout}, {31'd0, vt[v].e_lock});
            chk($sformatf("vec%0d_tent", v), {29'd0, tentativas}, {29'd0, vt[v].e_tent});
            chk($sformatf("vec%0d_idx", v), {28'd0, match_idx}, {28'd0, vt[v].e_idx});
        end

        // VERIFICAR lasts one cycle; unlock visible two edges after enter; relock at 20 cycles
        do_reset();
        aut = 16'd2;
        for (int i = 0; i < 4; i++) press(4'h0);
        key_code = 4'hF; key_valid = 1'b1;
        step();
        chk("verif_tranca", {31'd0, tranca}, 32'd1);
        chk("verif_lock", {31'd0, lockout}, 32'd0);
        key_valid = 1'b0;
        step();
        chk("unlock_tranca", {31'd0, tranca}, 32'd0);
        chk("unlock_idx", {28'd0, match_idx}, 32'h0);
        count_until_tranca(100, n);
        chk("autorelock_cycles", n, 20);

        // Setup mode and exit
        aut = 16'd1000;
        send_code(16'h1234);
        chk("setup_on", {31'd0, setup_on}, 32'd1);
        chk("setup_idx", {28'd0, match_idx}, 32'h8);
        setup_end = 1'b1;
        step();
        setup_end = 1'b0;
        chk("setup_exit", {31'd0, setup_on}, 32'd0);

        // Escalating lockout durations
        do_reset();
        exp_durs  = '{10, 10, 100, 200, 300, 300};
        exp_tents = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
        for (int f = 0; f < 6; f++) begin
            send_code(16'h9999);
            chk($sformatf("fail%0d_tent", f), {29'd0, tentativas}, {29'd0, exp_tents[f]});
            measure_lock(n);
            chk($sformatf("fail%0d_lockcycles", f), n, exp_durs[f]);
        end
        send_code(16'h0000);
        chk("success_clears_tent", {29'd0, tentativas}, 32'd0);
        botao = 1'b1; step(); botao = 1'b0;

        // Keys pressed during lockout are dropped
        do_reset();
        send_code(16'h9999);
        press(4'h0);
        press(4'h0);
        measure_lock(n);
        press(4'h0);
        press(4'h0);
        press(4'hF);
        chk("espera_ignores_keys", {29'd0, tentativas}, 32'd2);
        measure_lock(n);

        // Door-ajar alarm and count restart on close
        do_reset();
        aut = 16'd100; bip_time = 16'd1; bip_status = 1'b1;
        send_code(16'h0000);
        sensor = 1'b0;
        step();
        chk("aberta_bip0", {31'd0, bip}, 32'd0);
        chk("aberta_tranca", {31'd0, tranca}, 32'd0);
        n = 0;
        while (bip !== 1'b1 && n < 200) begin step(); n++; end
        chk("bip_delay", n, 10);
        sensor = 1'b1; aut = 16'd1;
        step();
        chk("close_bip0", {31'd0, bip}, 32'd0);
        chk("close_tranca", {31'd0, tranca}, 32'd0);
        count_until_tranca(200, n);
        chk("relock_after_close", n, 10);

        aut = 16'd0;
        send_code(16'h0000);
        chk("aut0_unlock", {31'd0, tranca}, 32'd0);
        count_until_tranca(50, n);
        chk("aut0_relock", n, 1);

        aut = 16'd100; bip_status = 1'b0; bip_time = 16'd0;
        send_code(16'h0000);
        sensor = 1'b0;
        repeat (15) step();
        chk("bip_disabled", {31'd0, bip}, 32'd0);
        sensor = 1'b1;
        step();
        botao = 1'b1; step(); botao = 1'b0;

        // botao_interno beats a simultaneous enter
        do_reset();
        for (int i = 0; i < 4; i++) press(4'h0);
        key_code = 4'hF; key_valid = 1'b1; botao = 1'b1;
        step();
        key_valid = 1'b0; botao = 1'b0;
        chk("botao_wins_tranca", {31'd0, tranca}, 32'd0);
        chk("botao_wins_idx", {28'd0, match_idx}, 32'hF);
        botao = 1'b1; step(); botao = 1'b0;
        chk("botao_relock", {31'd0, tranca}, 32'd1);

        // Reset mid-ESPERA and mid-ABERTA
        do_reset();
        send_code(16'h9999);
        step(); step();
        do_reset();
        chk_reset_vals("rst_espera");
        send_code(16'h0000);
        chk("rst_espera_unlock", {31'd0, tranca}, 32'd0);
        bip_status = 1'b1; bip_time = 16'd0;
        sensor = 1'b0;
        step(); step();
        chk("pre_rst_bip", {31'd0, bip}, 32'd1);
        do_reset();
        chk_reset_vals("rst_aberta");
        sensor = 1'b1;
        send_code(16'h0000);
        chk("rst_aberta_unlock", {31'd0, tranca}, 32'd0);
        chk("rst_aberta_idx", {28'd0, match_idx}, 32'h0);

        // Randomized entries against the outcome model
        do_reset();
        aut = 16'd1000; bip_status = 1'b0; sensor = 1'b1;
        tent_m = 0;
        for (int t = 0; t < 40; t++) begin
            int mode, kind, eidx;
            logic [15:0] val;
            m_master = rand_code();
            for (int s = 0; s < 4; s++) begin
                sd[s] = rand_code();
                st[s] = 1'($urandom_range(0, 1));
                set_slot(s, st[s], sd[s]);
            end
            master_pin = m_master;
            kq.delete();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) kq.push_back(4'($urandom_range(0, 9)));
                kq.push_back(4'hE);
            end
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin
                    int s = $urandom_range(0, 3);
                    for (int d = 3; d >= 0; d--) kq.push_back(sd[s][d*4 +: 4]);
                end
                1: for (int d = 3; d >= 0; d--) kq.push_back(m_master[d*4 +: 4]);
                2: repeat ($urandom_range(4, 6)) kq.push_back(4'($urandom_range(0, 9)));
                default: repeat ($urandom_range(0, 3)) kq.push_back(4'($urandom_range(0, 9)));
            endcase
            if ($urandom_range(0, 3) == 0)
                kq.insert($urandom_range(0, kq.size()), 4'($urandom_range(10, 13)));

            mb.delete();
            foreach (kq[i]) begin
                if (kq[i] <= 4'd9) begin
                    mb.push_back(kq[i]);
                    if (mb.size() > ND) void'(mb.pop_front());
                end else if (kq[i] == 4'hE) begin
                    mb.delete();
                end
            end
            kind = 0; eidx = 15; val = '0;
            if (mb.size() == ND) begin
                val = {mb[0], mb[1], mb[2], mb[3]};
                if (val == m_master) begin
                    kind = 2; eidx = 8;
                end else begin
                    for (int s = 3; s >= 0; s--)
                        if (st[s] && sd[s] == val) begin kind = 1; eidx = s; end
                end
            end
            if (kind == 0) tent_m = (tent_m == 5) ? 5 : tent_m + 1;
            else tent_m = 0;

            foreach (kq[i]) press(kq[i]);
            press(4'hF);
            chk($sformatf("rnd%0d_tranca", t), {31'd0, tranca}, (kind == 1) ? 32'd0 : 32'd1);
            chk($sformatf("rnd%0d_setup", t), {31'd0, setup_on}, (kind == 2) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_lock", t), {31'd0, lockout}, (kind == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_tent", t), {29'd0, tentativas}, tent_m);
            if (kind != 0) chk($sformatf("rnd%0d_idx", t), {28'd0, match_idx}, eidx);
            if (kind == 1) begin
                botao = 1'b1; step(); botao = 1'b0;
                chk($sformatf("rnd%0d_relock", t), {31'd0, tranca}, 32'd1);
            end else if (kind == 2) begin
                setup_end = 1'b1; step(); setup_end = 1'b0;
                chk($sformatf("rnd%0d_setup_exit", t), {31'd0, setup_on}, 32'd0);
            end else begin
                measure_lock(n);
                chk($sformatf("rnd%0d_lockcycles", t), n, lock_secs(tent_m) * HZ);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
